// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
//
// Shares one APB slave between N_REQ on-chip requesters. Requests are granted
// round-robin. Each grant runs one IDLE -> SETUP -> ACCESS transfer. The winner
// receives a one-cycle rsp_valid pulse with read data, or with rsp_err set when
// the slave has not raised pready within TIMEOUT ACCESS cycles.
//
// Ports
//   pclk, preset            clock, synchronous active-high reset
//   req_valid/req_write     per-requester request and direction (1 = write)
//   req_addr/req_wdata      flattened, requester i at [i*W +: W]
//   rsp_valid               one-hot completion pulse to the granted requester
//   rsp_rdata/rsp_err       completion payload; held until the next completion
//   psel/penable/pwrite     APB control (registered)
//   paddr/pwdata            APB address / write data (registered)
//   prdata/pready           APB slave response
// -----------------------------------------------------------------------------
module apb_master_arbiter #(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_W-1:0]       paddr,
    output logic [DATA_W-1:0]       pwdata,
    input  logic [DATA_W-1:0]       prdata,
    input  logic                    pready
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t              state_reg,     state_next;
    logic [PTR_W-1:0]    ptr_reg,       ptr_next;
    logic [PTR_W-1:0]    grant_reg,     grant_next;
    logic [CNT_W-1:0]    count_reg,     count_next;
    logic                psel_reg,      psel_next;
    logic                penable_reg,   penable_next;
    logic                pwrite_reg,    pwrite_next;
    logic [ADDR_W-1:0]   paddr_reg,     paddr_next;
    logic [DATA_W-1:0]   pwdata_reg,    pwdata_next;
    logic [N_REQ-1:0]    rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic                rsp_err_reg,   rsp_err_next;

    // -------------------------------------------------------------------------
    // Unpack the flattened requester buses
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_arr  [N_REQ];
    logic [DATA_W-1:0] wdata_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin search
    // The requester currently receiving its completion pulse is masked so a
    // request that is being withdrawn this very cycle cannot be re-issued.
    // -------------------------------------------------------------------------
    logic [N_REQ-1:0] eligible;
    logic             found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] cand;
    int               idx;

    always_comb begin
        eligible = req_valid & ~rsp_valid_reg;
        found    = 1'b0;
        win_idx  = ptr_reg;
        cand     = '0;
        idx      = 0;
        // Walk pointer+1 .. pointer+N_REQ (wrapping), first eligible wins.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = PTR_W'(idx);
            if (!found && eligible[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        grant_next     = grant_reg;
        count_next     = count_reg;
        psel_next      = psel_reg;
        penable_next   = penable_reg;
        pwrite_next    = pwrite_reg;
        paddr_next     = paddr_reg;
        pwdata_next    = pwdata_reg;
        rsp_valid_next = '0;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;

        case (state_reg)
            ST_IDLE: begin
                psel_next    = 1'b0;
                penable_next = 1'b0;
                if (found) begin
                    // Requester inputs are captured here only; the transfer
                    // in flight ignores any later change on them.
                    state_next  = ST_SETUP;
                    ptr_next    = win_idx;
                    grant_next  = win_idx;
                    pwrite_next = req_write[win_idx];
                    paddr_next  = addr_arr[win_idx];
                    pwdata_next = wdata_arr[win_idx];
                    count_next  = '0;
                    psel_next   = 1'b1;
                end
            end

            ST_SETUP: begin
                state_next   = ST_ACCESS;
                psel_next    = 1'b1;
                penable_next = 1'b1;
            end

            ST_ACCESS: begin
                count_next = count_reg + CNT_ONE;
                if (pready) begin
                    state_next                = ST_IDLE;
                    psel_next                 = 1'b0;
                    penable_next              = 1'b0;
                    rsp_valid_next[grant_reg] = 1'b1;
                    rsp_rdata_next            = pwrite_reg ? '0 : prdata;
                    rsp_err_next              = 1'b0;
                end else if (count_reg == CNT_LAST) begin
                    // Slave never answered: terminate with an error so the
                    // requester is not blocked forever.
                    state_next                = ST_IDLE;
                    psel_next                 = 1'b0;
                    penable_next              = 1'b0;
                    rsp_valid_next[grant_reg] = 1'b1;
                    rsp_rdata_next            = '0;
                    rsp_err_next              = 1'b1;
                end
            end

            default: begin
                state_next   = ST_IDLE;
                psel_next    = 1'b0;
                penable_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= PTR_LAST;
            grant_reg     <= '0;
            count_reg     <= '0;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            rsp_valid_reg <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            grant_reg     <= grant_next;
            count_reg     <= count_next;
            psel_reg      <= psel_next;
            penable_reg   <= penable_next;
            pwrite_reg    <= pwrite_next;
            paddr_reg     <= paddr_next;
            pwdata_reg    <= pwdata_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign psel      = psel_reg;
    assign penable   = penable_reg;
    assign pwrite    = pwrite_reg;
    assign paddr     = paddr_reg;
    assign pwdata    = pwdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

APB master that shares one APB slave (the peripheral RAM behind `apb_interface`) between N_REQ on-chip requesters. It arbitrates round-robin and drives a standard IDLE/SETUP/ACCESS APB transfer for each granted request. It returns read data or an error to the winning requester and bounds every transfer with a pready timeout. It sits between the requester logic and the single APB slave port.

## Interface
- N_REQ, 2, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max ACCESS cycles waiting for pready before error termination (>=1)

- pclk  in  1  clock; all logic on rising edge
- preset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  request pending, one bit per requester; held until that requester's rsp_valid
- req_write  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_W  flattened; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_REQ*DATA_W  flattened, same packing
- rsp_valid  out  N_REQ  one-cycle one-hot completion pulse
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid (0 for writes and errors)
- rsp_err  out  1  timeout flag, valid with rsp_valid
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB slave ready

## Operation
- All outputs are registered. Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. State is IDLE, last-grant pointer is N_REQ-1 (requester 0 wins first), and the timeout counter is 0.
- FSM states:
  - IDLE: psel=0, penable=0. If any eligible req_valid bit is set, grant the first set bit searching upward from pointer+1 (mod N_REQ). On grant: latch req_write/addr/wdata into pwrite/paddr/pwdata, record the grant index, update the pointer, go to SETUP.
  - SETUP: psel=1, penable=0. Go to ACCESS unconditionally.
  - ACCESS: psel=1, penable=1, counter increments each cycle.
    - If pready=1: capture prdata (reads only; writes return 0), pulse rsp_valid[grant], rsp_err=0, go to IDLE.
    - Else, if counter reaches TIMEOUT-1: pulse rsp_valid[grant], rsp_err=1, rsp_rdata=0, go to IDLE.
- Eligibility: in IDLE, the requester whose rsp_valid bit is currently high is masked. This prevents a re-issue while that requester drops req_valid in the same cycle.
- paddr, pwdata and pwrite hold stable from SETUP through the end of ACCESS. They keep their last values in IDLE.
- Requester inputs are sampled only at grant. Later changes do not affect the transfer in flight.
- A req_valid deasserted before grant is never issued. A deassertion after grant still completes the transfer and still produces rsp_valid.
- rsp_rdata and rsp_err hold their values until the next completion. rsp_valid is high for exactly one cycle per transfer.
- The counter clears on entry to SETUP.

## Timing
- Zero-wait transfer: req_valid seen in IDLE at cycle 0. psel=1 in cycle 1 (SETUP). penable=1 in cycle 2 (ACCESS, pready=1). rsp_valid in cycle 3 (IDLE). Latency is 3 cycles.
- Each wait-state cycle (pready=0 in ACCESS) adds one cycle.
- Timeout: rsp_valid/rsp_err arrive TIMEOUT+2 cycles after grant.
- Back-to-back: the next SETUP can start in cycle 4. Minimum issue interval is 3 cycles.
- Simultaneous requests in the same cycle: round-robin order from the pointer. No requester is starved; the worst-case wait is N_REQ-1 transfers.
- pready in IDLE or SETUP is ignored.
- Reset mid-transfer (any state): at the next edge all outputs take their reset values, no rsp_valid is produced for the aborted transfer, and the pointer returns to N_REQ-1.

## Test plan
- Single read: requester 0 reads 0x10, slave gives pready=1 in the first ACCESS cycle with prdata=0xDEADBEEF. Expect psel in cycle 1, penable in cycle 2, rsp_valid=2'b01 with rsp_rdata=0xDEADBEEF and rsp_err=0 in cycle 3.
- Write with 2 wait states: requester 1 writes 0x5A5A5A5A to 0x20. Expect paddr/pwdata/pwrite stable for 4 cycles of psel, rsp_valid=2'b10 in cycle 5, rsp_rdata=0.
- Contention: both requesters hold req_valid for 4 transfers after reset. Expect grant order 0,1,0,1 and exactly 4 rsp_valid pulses with no duplicates.
- Timeout: TIMEOUT=16, pready held 0. Expect ACCESS to last 16 cycles, then rsp_valid with rsp_err=1 and rsp_rdata=0, then IDLE with psel=0.
- Reset during ACCESS: assert preset while penable=1. Expect psel=penable=rsp_valid=0 on the next edge, no response, and requester 0 granted first after release.
- Early withdraw: requester 1 pulses req_valid for 1 cycle while requester 0's transfer is in flight. Expect no APB transfer for requester 1.
